// File: rtl/rpn_pkg.sv
// Shared opcode definitions for the RPN stack calculator.
package rpn_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_NEG  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MUL  = 3'd3,
    OP_SUB  = 3'd4,
    OP_DUP  = 3'd5,
    OP_SWAP = 3'd6,
    OP_POP  = 3'd7
  } op_e;

  function automatic logic is_binary(input op_e o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_MUL);
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage below top-of-stack: synchronous write, asynchronous read.
module stack_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN calculator: top of stack in a register, remaining entries in stack_ram.
// One command per rising edge of step; rejected commands pulse err.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          step,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  d,
  input  logic [2:0]    op,
  output logic [W-1:0]  out,
  output logic [CW-1:0] cnt,
  output logic          err,
  output logic          err_sticky
);

  localparam int AW = $clog2(DEPTH);

  op_e           op_v;
  logic [W-1:0]  out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          err_sticky_q, err_sticky_d;

  logic          full, has1, has2, ok;
  logic [W-1:0]  sec, alu_res;
  logic          ram_we, we;
  logic [AW-1:0] waddr, raddr;
  logic [W-1:0]  wdata;

  assign op_v = op_e'(op);
  assign full = (cnt_q == CW'(DEPTH));
  assign has1 = (cnt_q != '0);
  assign has2 = (cnt_q >= CW'(2));

  // Second element sits just below the slot the top would spill into.
  assign raddr = AW'(cnt_q - CW'(2));

  stack_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clk   (step),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (sec)
  );

  always_comb begin
    ok = 1'b1;
    if (push) begin
      ok = !full;
    end else begin
      case (op_v)
        OP_NEG, OP_POP:           ok = has1;
        OP_ADD, OP_SUB, OP_MUL,
        OP_SWAP:                  ok = has2;
        OP_DUP:                   ok = has1 && !full;
        default:                  ok = 1'b1;
      endcase
    end
  end

  always_comb begin
    alu_res = out_q;
    case (op_v)
      OP_NEG:  alu_res = -out_q;
      OP_ADD:  alu_res = sec + out_q;
      OP_SUB:  alu_res = sec - out_q;
      OP_MUL:  alu_res = sec * out_q;
      OP_SWAP: alu_res = sec;
      OP_POP:  alu_res = has2 ? sec : '0;
      default: alu_res = out_q;
    endcase
  end

  always_comb begin
    out_d        = out_q;
    cnt_d        = cnt_q;
    err_d        = !ok;
    err_sticky_d = err_sticky_q | !ok;
    ram_we       = 1'b0;
    waddr        = AW'(cnt_q - CW'(1));
    wdata        = out_q;
    if (ok) begin
      if (push) begin
        ram_we = has1;
        out_d  = d;
        cnt_d  = cnt_q + CW'(1);
      end else begin
        case (op_v)
          OP_NEG: out_d = alu_res;
          OP_ADD, OP_SUB, OP_MUL, OP_POP: begin
            out_d = alu_res;
            cnt_d = cnt_q - CW'(1);
          end
          OP_DUP: begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
          OP_SWAP: begin
            ram_we = 1'b1;
            waddr  = raddr;
            out_d  = alu_res;
          end
          default: ;
        endcase
      end
    end
  end

  // Reset wins over any same-cycle command, including its RAM write.
  assign we = ram_we && !rst;

  always_ff @(posedge step) begin
    if (rst) begin
      out_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out        = out_q;
  assign cnt        = cnt_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Scoreboarded bench for rpn_stack_calc (W=16, DEPTH=4): directed scenarios
// followed by random commands checked against a queue-based stack model.
module tb_rpn_stack_calc;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [W-1:0]  o;
    logic [CW-1:0] c;
    logic          e;
    logic          s;
  } resp_t;

  logic          step = 1'b0;
  logic          rst  = 1'b1;
  logic          push = 1'b0;
  logic [W-1:0]  d    = '0;
  logic [2:0]    op   = 3'd0;
  logic [W-1:0]  out;
  logic [CW-1:0] cnt;
  logic          err;
  logic          err_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  resp_t       exp_q[$];
  logic [W-1:0] stk[$];
  logic         m_sticky = 1'b0;
  logic         m_err    = 1'b0;

  rpn_stack_calc #(.W(W), .DEPTH(DEPTH)) dut (
    .step       (step),
    .rst        (rst),
    .push       (push),
    .d          (d),
    .op         (op),
    .out        (out),
    .cnt        (cnt),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 step = ~step;

  function automatic resp_t model_view();
    resp_t r;
    r.o = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    r.c = CW'(stk.size());
    r.e = m_err;
    r.s = m_sticky;
    return r;
  endfunction

  // Reference: stack as a queue, top at the back.
  task automatic model_step(input logic r, input logic p, input logic [W-1:0] dv,
                            input logic [2:0] o);
    logic [W-1:0] a, b, res;
    int n;
    n = stk.size();
    m_err = 1'b0;
    if (r) begin
      stk.delete();
      m_sticky = 1'b0;
      return;
    end
    if (p) begin
      if (n < DEPTH) stk.push_back(dv);
      else m_err = 1'b1;
    end else begin
      case (o)
        3'd1: if (n >= 1) stk[n-1] = -stk[n-1]; else m_err = 1'b1;
        3'd2, 3'd3, 3'd4: begin
          if (n >= 2) begin
            a = stk.pop_back();
            b = stk.pop_back();
            if (o == 3'd2)      res = b + a;
            else if (o == 3'd3) res = b * a;
            else                res = b - a;
            stk.push_back(res);
          end else m_err = 1'b1;
        end
        3'd5: if (n >= 1 && n < DEPTH) stk.push_back(stk[n-1]); else m_err = 1'b1;
        3'd6: begin
          if (n >= 2) begin
            a = stk[n-1];
            stk[n-1] = stk[n-2];
            stk[n-2] = a;
          end else m_err = 1'b1;
        end
        3'd7: if (n >= 1) void'(stk.pop_back()); else m_err = 1'b1;
        default: ;
      endcase
    end
    if (m_err) m_sticky = 1'b1;
  endtask

  task automatic cmd(input logic r, input logic p, input logic [W-1:0] dv,
                     input logic [2:0] o);
    @(negedge step);
    rst  = r;
    push = p;
    d    = dv;
    op   = o;
    model_step(r, p, dv, o);
    exp_q.push_back(model_view());
  endtask

  // Directed spot check against hand-derived values after the edge.
  task automatic expect_now(input string name, input logic [W-1:0] eo,
                            input int ec, input logic ee, input logic es);
    @(posedge step);
    #2;
    n_tests++;
    if (out !== eo || cnt !== CW'(ec) || err !== ee || err_sticky !== es) begin
      n_fail++;
      $display("FAIL %s: got out=%h cnt=%0d err=%b sticky=%b, want out=%h cnt=%0d err=%b sticky=%b",
               name, out, cnt, err, err_sticky, eo, ec, ee, es);
    end
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(posedge step);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (out !== e.o || cnt !== e.c || err !== e.e || err_sticky !== e.s) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got out=%h cnt=%0d err=%b sticky=%b, want out=%h cnt=%0d err=%b sticky=%b",
                   $time, out, cnt, err, err_sticky, e.o, e.c, e.e, e.s);
        end
      end
    end
  end

  initial begin : driver
    logic [2:0] ro;
    logic rp, rr;
    cmd(1, 0, 0, 0);                    expect_now("reset", 16'h0, 0, 0, 0);
    cmd(0, 1, 3, 0);
    cmd(0, 1, 4, 0);
    cmd(0, 0, 0, 3'd2);                 expect_now("add", 16'd7, 1, 0, 0);
    cmd(0, 0, 0, 3'd1);                 expect_now("neg", 16'hFFF9, 1, 0, 0);

    cmd(1, 0, 0, 0);
    cmd(0, 1, 10, 0);
    cmd(0, 1, 3, 0);
    cmd(0, 0, 0, 3'd4);                 expect_now("sub", 16'd7, 1, 0, 0);
    cmd(0, 1, 16'h0100, 0);
    cmd(0, 1, 16'h0100, 0);
    cmd(0, 0, 0, 3'd3);                 expect_now("mul_trunc", 16'h0000, 2, 0, 0);

    cmd(1, 0, 0, 0);
    cmd(0, 1, 1, 0);
    cmd(0, 1, 2, 0);
    cmd(0, 1, 3, 0);
    cmd(0, 0, 0, 3'd6);                 expect_now("swap", 16'd2, 3, 0, 0);
    cmd(0, 0, 0, 3'd7);                 expect_now("pop", 16'd3, 2, 0, 0);
    cmd(0, 0, 0, 3'd5);                 expect_now("dup", 16'd3, 3, 0, 0);

    cmd(1, 0, 0, 0);
    cmd(0, 0, 0, 3'd2);                 expect_now("underflow_add", 16'd0, 0, 1, 1);
    cmd(0, 0, 0, 3'd0);                 expect_now("err_one_cycle", 16'd0, 0, 0, 1);
    cmd(0, 1, 5, 0);
    cmd(0, 0, 0, 3'd4);                 expect_now("underflow_sub", 16'd5, 1, 1, 1);

    cmd(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cmd(0, 1, W'(i), 0);
    cmd(0, 1, 9, 0);                    expect_now("overflow_push", 16'd4, 4, 1, 1);
    cmd(0, 0, 0, 3'd5);                 expect_now("overflow_dup", 16'd4, 4, 1, 1);
    cmd(0, 0, 0, 3'd2);
    cmd(0, 0, 0, 3'd2);
    cmd(0, 0, 0, 3'd2);                 expect_now("add_chain", 16'd10, 1, 0, 1);

    cmd(1, 0, 0, 0);
    cmd(0, 1, 16'h1234, 3'd2);          expect_now("push_over_op", 16'h1234, 1, 0, 0);

    cmd(0, 0, 0, 3'd7);
    cmd(0, 0, 0, 3'd7);                 expect_now("pop_empty", 16'h1234 & 16'h0, 0, 1, 1);
    cmd(0, 1, 7, 0);
    cmd(0, 1, 8, 0);
    cmd(0, 1, 9, 0);
    cmd(1, 1, 16'hBEEF, 0);             expect_now("rst_over_push", 16'd0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      rp = ($urandom_range(0, 99) < 40);
      ro = 3'($urandom_range(0, 7));
      cmd(rr, rp, ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 20)), ro);
    end

    @(negedge step);
    rst = 1'b0; push = 1'b0; op = 3'd0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge step);
    #3;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
